// File: rtl/quad_encoder_gen_if.sv
// Command channel of the quadrature generator: valid/ready handshake plus
// the step command (direction, edge count, edge period).
interface quad_encoder_gen_if #(
  parameter int STEPS_W = 10,
  parameter int PER_W   = 16
) ();
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_dir;
  logic [STEPS_W-1:0] cmd_steps;
  logic [PER_W-1:0]   cmd_period;

  modport master (
    output cmd_valid, cmd_dir, cmd_steps, cmd_period,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_dir, cmd_steps, cmd_period,
    output cmd_ready
  );
endinterface

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator emulating a rotary encoder; emits a commanded number
// of Gray-coded edges at a fixed period. Optional index output under QUAD_INDEX_Z_EN.
module quad_encoder_gen #(
  parameter int STEPS_W       = 10,
  parameter int PER_W         = 16,
  parameter int POS_W         = 10,
  parameter int EDGES_PER_REV = 96
) (
  input  logic               clk,
  input  logic               reset,
  quad_encoder_gen_if.slave  cmd,
  input  logic               abort,
  output logic               A,
  output logic               B,
  output logic               busy,
  output logic               done,
  output logic [POS_W-1:0]   pos,
  output logic               Z
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             r_state;
  logic               r_dir;
  logic [STEPS_W-1:0] r_left;
  logic [PER_W-1:0]   r_period;
  logic [PER_W-1:0]   r_tick;
  logic               r_a;
  logic               r_b;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;
  logic [POS_W-1:0]   r_pos;

  logic [PER_W-1:0]   w_period_clamped;
  logic               w_toggle_a;
  logic               w_emit;
  logic [POS_W-1:0]   w_pos_next;

  always_comb begin
    w_period_clamped = (cmd.cmd_period < PER_W'(4)) ? PER_W'(4) : cmd.cmd_period;
    // Forward toggles A when A==B, reverse toggles A when A!=B; B otherwise.
    w_toggle_a       = r_dir ? (r_a == r_b) : (r_a != r_b);
    w_pos_next       = r_dir ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
    w_emit           = (r_state == S_RUN) && !abort && (r_left != '0) && (r_tick == r_period);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_dir    <= 1'b0;
      r_left   <= '0;
      r_period <= PER_W'(4);
      r_tick   <= PER_W'(1);
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
      r_pos    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            r_dir    <= cmd.cmd_dir;
            r_left   <= cmd.cmd_steps;
            r_period <= w_period_clamped;
            r_tick   <= PER_W'(1);
            if (cmd.cmd_steps == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // Last edge already out (or aborted): one more cycle, then done.
          if (abort || (r_left == '0)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_emit) begin
            r_tick <= PER_W'(1);
            r_left <= r_left - STEPS_W'(1);
            r_pos  <= w_pos_next;
            if (w_toggle_a) r_a <= ~r_a;
            else            r_b <= ~r_b;
          end else begin
            r_tick <= r_tick + PER_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd.cmd_ready = r_ready;
  assign A             = r_a;
  assign B             = r_b;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pos           = r_pos;

`ifdef QUAD_INDEX_Z_EN
  localparam int REV_W = $clog2(EDGES_PER_REV);

  logic [REV_W-1:0] r_rev;
  logic [REV_W-1:0] w_rev_next;
  logic             r_z;

  always_comb begin
    if (r_dir) w_rev_next = (r_rev == REV_W'(EDGES_PER_REV - 1)) ? '0 : (r_rev + REV_W'(1));
    else       w_rev_next = (r_rev == '0) ? REV_W'(EDGES_PER_REV - 1) : (r_rev - REV_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rev <= '0;
      r_z   <= 1'b1;
    end else if (w_emit) begin
      r_rev <= w_rev_next;
      r_z   <= (w_rev_next == '0);
    end
  end

  assign Z = r_z;
`else
  // Index disabled: Z is constant 0 for any legal revolution size.
  assign Z = 1'b0 & (EDGES_PER_REV > 0);
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Bench for quad_encoder_gen: arithmetic edge-schedule model checked every cycle,
// plus directed scenarios with literal expectations (Z checks need QUAD_INDEX_Z_EN).
module tb_quad_encoder_gen;

  localparam int POS_M = 1024;
  localparam int EPR   = 96;
  localparam int NEVER = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       abort = 1'b0;
  logic       A, B, busy, done, Z;
  logic [9:0] pos;
  bit         chk_en = 1'b0;

  int checks = 0;
  int failures = 0;

  quad_encoder_gen_if #(.STEPS_W(10), .PER_W(16)) u_if ();

  quad_encoder_gen #(
    .STEPS_W(10), .PER_W(16), .POS_W(10), .EDGES_PER_REV(EPR)
  ) dut (
    .clk(clk), .reset(rst), .cmd(u_if), .abort(abort),
    .A(A), .B(B), .busy(busy), .done(done), .pos(pos), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: command as an edge schedule ----------------
  int  e;                          // posedges since reset
  bit  m_act;
  bit  m_dir;
  int  m_a, m_n, m_p, m_D, m_ab;   // accept edge, edges, period, done edge, abort edge
  int  m_pos, m_ph, m_rev;         // state before the current command
  logic [1:0] x_ab;
  int  x_pos;
  bit  x_busy, x_done, x_ready, x_z;

  function automatic int pmod(input int v, input int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic logic [1:0] ab_of(input int i);
    case (i)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  // Edges of the current command visible after posedge ee.
  function automatic int edges_at(input int ee);
    int t, k;
    if (!m_act) return 0;
    t = (ee > m_ab - 1) ? m_ab - 1 : ee;
    if (t < m_a) return 0;
    k = (t - m_a) / m_p;
    return (k > m_n) ? m_n : k;
  endfunction

  function automatic void refresh();
    int s;
    s = m_dir ? edges_at(e) : -edges_at(e);
    x_ab    = ab_of(pmod(m_ph + s, 4));
    x_pos   = pmod(m_pos + s, POS_M);
    x_busy  = m_act && (m_n > 0) && (e < m_D);
    x_done  = m_act && (e == m_D);
    x_ready = !(m_act && (e < m_D));
`ifdef QUAD_INDEX_Z_EN
    x_z = (pmod(m_rev + s, EPR) == 0);
`else
    x_z = 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    int s;
    if (rst) begin
      e = 0; m_act = 0; m_pos = 0; m_ph = 0; m_rev = 0;
      refresh();
    end else begin
      e++;
      if (m_act && (e - 1 >= m_D)) begin
        s = m_dir ? edges_at(m_D) : -edges_at(m_D);
        m_pos = pmod(m_pos + s, POS_M);
        m_ph  = pmod(m_ph + s, 4);
        m_rev = pmod(m_rev + s, EPR);
        m_act = 0;
      end
      if (m_act && abort && (e > m_a) && (e <= m_D)) begin
        m_D  = e;
        m_ab = e;
      end else if (!m_act && u_if.cmd_valid) begin
        m_act = 1;
        m_a   = e;
        m_dir = u_if.cmd_dir;
        m_n   = int'(u_if.cmd_steps);
        m_p   = (u_if.cmd_period < 16'd4) ? 4 : int'(u_if.cmd_period);
        m_ab  = NEVER;
        m_D   = (m_n == 0) ? e : e + m_n * m_p + 1;
      end
      refresh();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_AB",    {30'd0, A, B}, {30'd0, x_ab});
      check("cyc_pos",   {22'd0, pos},  x_pos);
      check("cyc_busy",  {31'd0, busy}, {31'd0, x_busy});
      check("cyc_done",  {31'd0, done}, {31'd0, x_done});
      check("cyc_ready", {31'd0, u_if.cmd_ready}, {31'd0, x_ready});
      check("cyc_Z",     {31'd0, Z},    {31'd0, x_z});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!x_ready && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!x_ready) begin
      failures++;
      $display("FAIL wait_idle: timed out after %0d cycles", budget);
    end
  endtask

  // Returns at #1 after the accept edge.
  task automatic send(input bit d, input int s, input int p);
    @(posedge clk); #1;
    u_if.cmd_valid  = 1'b1;
    u_if.cmd_dir    = d;
    u_if.cmd_steps  = 10'(s);
    u_if.cmd_period = 16'(p);
    @(posedge clk); #1;
    u_if.cmd_valid  = 1'b0;
  endtask

  logic [1:0] t1_ab [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] t2_ab [3] = '{2'b01, 2'b11, 2'b10};

  initial begin
    u_if.cmd_valid = 1'b0; u_if.cmd_dir = 1'b0; u_if.cmd_steps = '0; u_if.cmd_period = '0;
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    check("rst_AB",    {30'd0, A, B}, 32'd0);
    check("rst_pos",   {22'd0, pos}, 32'd0);
    check("rst_ready", {31'd0, u_if.cmd_ready}, 32'd1);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: forward 8 edges, period 10
    send(1'b1, 8, 10);
    for (int j = 0; j < 8; j++) begin
      repeat (9) @(posedge clk); #1;
      check("t1_hold", {30'd0, A, B}, {30'd0, (j == 0) ? 2'b00 : t1_ab[j-1]});
      @(posedge clk); #1;
      check("t1_edge", {30'd0, A, B}, {30'd0, t1_ab[j]});
    end
    check("t1_nodone_yet", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_pos",  {22'd0, pos}, 32'd8);

    // 2: reverse 3 edges, period 2 clamped to 4; then forward across the wrap
    do_reset();
    send(1'b0, 3, 2);
    for (int j = 0; j < 3; j++) begin
      repeat (3) @(posedge clk); #1;
      check("t2_hold", {30'd0, A, B}, {30'd0, (j == 0) ? 2'b00 : t2_ab[j-1]});
      @(posedge clk); #1;
      check("t2_edge", {30'd0, A, B}, {30'd0, t2_ab[j]});
    end
    wait_idle(20);
    check("t2_pos", {22'd0, pos}, 32'h3FD);
    send(1'b1, 4, 4);
    wait_idle(40);
    check("t2_wrap_pos", {22'd0, pos}, 32'd1);
    check("t2_wrap_AB",  {30'd0, A, B}, 32'b10);

    // 3: zero steps
    send(1'b1, 0, 7);
    check("t3_done",  {31'd0, done}, 32'd1);
    check("t3_ready", {31'd0, u_if.cmd_ready}, 32'd1);
    check("t3_AB",    {30'd0, A, B}, 32'b10);

    // 4: abort after the 7th edge, then a command continuing from the held phase
    do_reset();
    send(1'b1, 100, 5);
    repeat (35) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_pos",  {22'd0, pos}, 32'd7);
    repeat (20) @(posedge clk); #1;
    check("t4_hold_AB", {30'd0, A, B}, 32'b01);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    send(1'b0, 5, 4);
    wait_idle(40);
    check("t4_cont_pos", {22'd0, pos}, 32'd2);
    check("t4_cont_AB",  {30'd0, A, B}, 32'b11);

    // 5: loop-back totals
    do_reset();
    send(1'b1, 400, 4);
    wait_idle(2000);
    send(1'b0, 100, 4);
    wait_idle(600);
    check("t5_pos",  {22'd0, pos}, 32'd300);
    check("t5_out8", {24'd0, pos[9:2]}, 32'd75);

`ifdef QUAD_INDEX_Z_EN
    // 6: index over one revolution
    do_reset();
    check("t6_z_start", {31'd0, Z}, 32'd1);
    send(1'b1, 96, 4);
    repeat (4) @(posedge clk); #1;
    check("t6_z_edge1", {31'd0, Z}, 32'd0);
    wait_idle(500);
    check("t6_z_rev", {31'd0, Z}, 32'd1);
    send(1'b0, 1, 4);
    wait_idle(20);
    check("t6_z_back", {31'd0, Z}, 32'd0);
`endif

    // reset mid-command
    send(1'b1, 50, 4);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mr_AB",    {30'd0, A, B}, 32'd0);
    check("mr_pos",   {22'd0, pos}, 32'd0);
    check("mr_ready", {31'd0, u_if.cmd_ready}, 32'd1);
    check("mr_busy",  {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(1'b1, 3, 4);
    wait_idle(40);
    check("mr_after_pos", {22'd0, pos}, 32'd3);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
